// File: rtl/truth_table_sweeper.sv
// Self-check sequencer for a 4-input combinational unit: sweeps all 16 input vectors,
// captures the unit's output into a truth table and compares it against an expected table.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CW     = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [15:0] iExpected,
  input  logic        iY,
  output logic        oA,
  output logic        oB,
  output logic        oC,
  output logic        oD,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oTable,
  output logic [4:0]  oErrCnt,
  output logic [3:0]  oFirstErr,
  output logic        oPass
);

  typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   table_q, table_d;
  logic [4:0]    err_cnt_q, err_cnt_d;
  logic [3:0]    first_err_q, first_err_d;
  logic          pass_q, pass_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      table_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      table_q     <= table_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    table_d     = table_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;

    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          state_d     = StApply;
          idx_d       = '0;
          cnt_d       = '0;
          table_d     = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
        end
      end
      StApply: begin
        if (iAbort) begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        // Abort wins over the capture scheduled for this cycle.
        if (iAbort) begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          table_d[idx_q] = iY;
          if (iY != iExpected[idx_q]) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (err_cnt_q == 5'd0) begin
              first_err_d = idx_q;
            end
          end
          if (idx_q == 4'd15) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = '0;
            state_d = StApply;
          end
        end
      end
      StDone: begin
        pass_d  = (err_cnt_q == 5'd0);
        idx_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [3:0] vec;

  always_comb begin
    oBusy = (state_q == StApply) || (state_q == StSample);
    oDone = (state_q == StDone);
    vec   = oBusy ? idx_q : 4'b0000;
  end

  assign oA        = vec[3];
  assign oB        = vec[2];
  assign oC        = vec[1];
  assign oD        = vec[0];
  assign oTable    = table_q;
  assign oErrCnt   = err_cnt_q;
  assign oFirstErr = first_err_q;
  assign oPass     = pass_q;

endmodule
